// File: rtl/i2s_rx_master.sv
// I2S master receiver: generates BCLK/WS from sys_clk, deserialises stereo sdata
// and queues complete {left, right} frames in a small FIFO with valid/ready output.
module i2s_rx_master #(
  parameter int DATA_W     = 24,
  parameter int SLOT_W     = 32,
  parameter int BCLK_DIV   = 4,
  parameter int MODE       = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              sys_clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic              sdata,
  output logic              bclk,
  output logic              ws,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_left,
  output logic [DATA_W-1:0] out_right,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam int BIT_W = $clog2(2 * SLOT_W);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int OFS   = (MODE == 0) ? 1 : 0;

  localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0] SLOT     = BIT_W'(SLOT_W);
  localparam logic [BIT_W-1:0] K_FIRST  = BIT_W'(OFS);
  localparam logic [BIT_W-1:0] K_LAST   = BIT_W'(OFS + DATA_W - 1);
  localparam logic [BIT_W-1:0] N_DATA   = BIT_W'(DATA_W);
  localparam logic [AW:0]      FULL_LVL = (AW + 1)'(FIFO_DEPTH);

  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BIT_W-1:0]  bit_nxt;
  logic [BIT_W-1:0]  slot_k;
  logic [BIT_W-1:0]  k_rel;
  logic              tc, rise, fall, in_right, cap, last_bit;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_nxt;
  logic [DATA_W-1:0] left_hold;

  logic              vld_p0;
  logic [DATA_W-1:0] left_p0;
  logic [DATA_W-1:0] right_p0;

  logic [DATA_W-1:0] mem_l [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr, vis_ptr;
  logic [AW:0]       fill;
  logic              full, pop, push_ok;

  assign tc        = (div_cnt == DIV_TC);
  assign rise      = enable && tc && !bclk;
  assign fall      = enable && tc && bclk;
  assign bit_nxt   = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
  assign in_right  = (bit_cnt >= SLOT);
  assign slot_k    = in_right ? bit_cnt - SLOT : bit_cnt;
  // Unsigned wrap makes k below the offset land far above the window.
  assign k_rel     = slot_k - K_FIRST;
  assign cap       = rise && (k_rel < N_DATA);
  assign last_bit  = (slot_k == K_LAST);
  assign shift_nxt = {shift[DATA_W-2:0], sdata};

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      ws      <= 1'b0;
      bit_cnt <= '0;
      shift   <= '0;
    end else if (!enable) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      ws      <= 1'b0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      div_cnt <= tc ? '0 : div_cnt + DIV_W'(1);
      if (tc)   bclk <= ~bclk;
      if (fall) begin
        bit_cnt <= bit_nxt;
        ws      <= (bit_nxt >= SLOT);
      end
      if (cap)  shift <= shift_nxt;
    end
  end

  // Stage p0: completed frame waiting one edge before the FIFO write
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      left_hold <= '0;
      vld_p0    <= 1'b0;
      left_p0   <= '0;
      right_p0  <= '0;
    end else begin
      vld_p0 <= cap && last_bit && in_right;
      if (cap && last_bit && !in_right) left_hold <= shift_nxt;
      if (cap && last_bit && in_right) begin
        left_p0  <= left_hold;
        right_p0 <= shift_nxt;
      end
    end
  end

  assign fill    = wr_ptr - rd_ptr;
  assign full    = (fill == FULL_LVL);
  assign pop     = out_valid && out_ready;
  assign push_ok = vld_p0 && (!full || pop);

  always_ff @(posedge sys_clk) begin
    if (push_ok) begin
      mem_l[wr_ptr[AW-1:0]] <= left_p0;
      mem_r[wr_ptr[AW-1:0]] <= right_p0;
    end
  end

  // vis_ptr trails wr_ptr by one edge so a written entry is exposed a cycle later
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      vis_ptr  <= '0;
      overflow <= 1'b0;
    end else begin
      vis_ptr <= wr_ptr;
      if (push_ok) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW + 1)'(1);
      if (vld_p0 && full && !pop) overflow <= 1'b1;
      else if (ovf_clr)           overflow <= 1'b0;
    end
  end

  assign out_valid = (vis_ptr != rd_ptr);
  assign out_left  = out_valid ? mem_l[rd_ptr[AW-1:0]] : '0;
  assign out_right = out_valid ? mem_r[rd_ptr[AW-1:0]] : '0;

endmodule

// File: tb/tb_i2s_rx_master.sv
// Directed bench for i2s_rx_master: a Philips-mode and a left-justified instance
// share one serial stream; expected words are hand-derived.
module tb_i2s_rx_master;
  localparam int DATA_W     = 24;
  localparam int SLOT_W     = 32;
  localparam int BCLK_DIV   = 4;
  localparam int FIFO_DEPTH = 4;

  logic              sys_clk = 1'b0;
  logic              rstn = 1'b0;
  logic              enable = 1'b1;
  logic              sdata = 1'b0;
  logic              out_ready = 1'b1;
  logic              out_ready1 = 1'b1;
  logic              ovf_clr = 1'b0;

  logic              bclk0, ws0, out_valid0, overflow0;
  logic [DATA_W-1:0] out_left0, out_right0;
  logic              bclk1, ws1, out_valid1, overflow1;
  logic [DATA_W-1:0] out_left1, out_right1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = 0;
  int v0_rise_cyc = -1, v1_rise_cyc = -1;
  int v0_hi = 0, v1_hi = 0;
  logic v0_prev = 1'b0, v1_prev = 1'b0;
  logic [DATA_W-1:0] c0_l = '0, c0_r = '0, c1_l = '0, c1_r = '0;

  i2s_rx_master #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .BCLK_DIV(BCLK_DIV), .MODE(0),
                  .FIFO_DEPTH(FIFO_DEPTH)) dut0 (
    .sys_clk(sys_clk), .rstn(rstn), .enable(enable), .sdata(sdata),
    .bclk(bclk0), .ws(ws0), .out_valid(out_valid0), .out_ready(out_ready),
    .out_left(out_left0), .out_right(out_right0), .overflow(overflow0), .ovf_clr(ovf_clr)
  );

  i2s_rx_master #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .BCLK_DIV(BCLK_DIV), .MODE(1),
                  .FIFO_DEPTH(FIFO_DEPTH)) dut1 (
    .sys_clk(sys_clk), .rstn(rstn), .enable(enable), .sdata(sdata),
    .bclk(bclk1), .ws(ws1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_left(out_left1), .out_right(out_right1), .overflow(overflow1), .ovf_clr(ovf_clr)
  );

  always #5 sys_clk = ~sys_clk;

  // Output monitor: records when out_valid rises and the head frame at that moment
  initial begin : monitor
    forever begin
      @(posedge sys_clk);
      cyc++;
      #3;
      if (out_valid0) v0_hi++;
      if (out_valid0 && !v0_prev) begin
        v0_rise_cyc = cyc; c0_l = out_left0; c0_r = out_right0;
      end
      v0_prev = out_valid0;
      if (out_valid1) v1_hi++;
      if (out_valid1 && !v1_prev) begin
        v1_rise_cyc = cyc; c1_l = out_left1; c1_r = out_right1;
      end
      v1_prev = out_valid1;
    end
  end

  function automatic logic slot_bit(input logic [DATA_W-1:0] w, input int k, input int d);
    if (k >= d && k < d + DATA_W) return w[DATA_W-1-(k-d)];
    return 1'b0;
  endfunction

  task automatic wait_rise(output bit ok);
    int   n;
    logic pb;
    n  = 0;
    ok = 1'b0;
    pb = bclk0;
    while (n < 4 * BCLK_DIV) begin
      @(posedge sys_clk); #1;
      n++;
      if (!pb && bclk0) begin
        ok = 1'b1;
        break;
      end
      pb = bclk0;
    end
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                            input int d, input int nbits);
    bit ok;
    for (int b = 0; b < nbits; b++) begin
      sdata = (b < SLOT_W) ? slot_bit(l, b % SLOT_W, d) : slot_bit(r, b % SLOT_W, d);
      wait_rise(ok);
      if (!ok) begin
        checks++; errors++;
        $display("FAIL bclk_rise_timeout: no bclk rise at bit %0d, required one within %0d cycles",
                 b, 4 * BCLK_DIV);
        sdata = 1'b0;
        return;
      end
      if (b == SLOT_W + d + DATA_W - 1) last_cyc = cyc;
    end
    sdata = 1'b0;
  endtask

  task automatic restart(input logic rdy);
    @(posedge sys_clk); #1;
    enable    = 1'b0;
    out_ready = 1'b1;
    repeat (FIFO_DEPTH + 2) begin
      @(posedge sys_clk); #1;
    end
    out_ready   = rdy;
    sdata       = 1'b0;
    v0_hi       = 0;
    v1_hi       = 0;
    v0_rise_cyc = -1;
    v1_rise_cyc = -1;
    enable      = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    rstn = 1'b0; enable = 1'b1;
    repeat (5) @(posedge sys_clk);
    #1;
    checks++; if (bclk0 !== 1'b0) begin errors++; $display("FAIL reset_bclk: got %b, want 0", bclk0); end
    checks++; if (ws0 !== 1'b0) begin errors++; $display("FAIL reset_ws: got %b, want 0", ws0); end
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, want 0", out_valid0); end
    checks++; if (overflow0 !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b, want 0", overflow0); end
    checks++; if (out_left0 !== '0) begin errors++; $display("FAIL reset_left: got %h, want 0", out_left0); end
    rstn = 1'b1;
    n = 0;
    while (bclk0 !== 1'b1 && n < 20) begin
      @(posedge sys_clk); #1;
      n++;
    end
    checks++; if (n != BCLK_DIV) begin errors++; $display("FAIL first_rise: got cycle %0d, want %0d", n, BCLK_DIV); end
  endtask

  task automatic test_clocking();
    int r1, r2, w1, w2, viol, hi;
    logic pb, pw;
    r1 = -1; r2 = -1; w1 = -1; w2 = -1; viol = 0; hi = 0;
    restart(1'b1);
    pb = bclk0; pw = ws0;
    for (int i = 0; i < 1100; i++) begin
      @(posedge sys_clk); #1;
      if (!pb && bclk0) begin
        if (r1 < 0) r1 = i;
        else if (r2 < 0) r2 = i;
      end
      if (bclk0 && r1 >= 0 && r2 < 0) hi++;
      if (ws0 !== pw) begin
        if (!(pb && !bclk0)) viol++;
        if (ws0 && !pw) begin
          if (w1 < 0) w1 = i;
          else if (w2 < 0) w2 = i;
        end
      end
      pb = bclk0; pw = ws0;
    end
    checks++; if (r2 - r1 != 2 * BCLK_DIV) begin errors++; $display("FAIL bclk_period: got %0d, want %0d", r2 - r1, 2 * BCLK_DIV); end
    checks++; if (hi != BCLK_DIV) begin errors++; $display("FAIL bclk_high: got %0d, want %0d", hi, BCLK_DIV); end
    checks++; if (w2 - w1 != 512) begin errors++; $display("FAIL ws_period: got %0d, want 512", w2 - w1); end
    checks++; if (viol != 0) begin errors++; $display("FAIL ws_on_fall: got %0d misaligned ws changes, want 0", viol); end
  endtask

  task automatic test_mode0();
    restart(1'b1);
    send_frame(24'hA5A5A5, 24'h5A5A5A, 1, 2 * SLOT_W);
    checks++; if (c0_l !== 24'hA5A5A5) begin errors++; $display("FAIL mode0_left: got %h, want a5a5a5", c0_l); end
    checks++; if (c0_r !== 24'h5A5A5A) begin errors++; $display("FAIL mode0_right: got %h, want 5a5a5a", c0_r); end
    checks++; if (v0_rise_cyc - last_cyc != 2) begin errors++; $display("FAIL mode0_latency: got %0d, want 2", v0_rise_cyc - last_cyc); end
    checks++; if (v0_hi != 1) begin errors++; $display("FAIL mode0_pulse: got %0d valid cycles, want 1", v0_hi); end
  endtask

  task automatic test_mode1();
    restart(1'b1);
    send_frame(24'h800001, 24'h7FFFFE, 0, 2 * SLOT_W);
    checks++; if (c1_l !== 24'h800001) begin errors++; $display("FAIL mode1_left: got %h, want 800001", c1_l); end
    checks++; if (c1_r !== 24'h7FFFFE) begin errors++; $display("FAIL mode1_right: got %h, want 7ffffe", c1_r); end
    checks++; if (v1_rise_cyc - last_cyc != 2) begin errors++; $display("FAIL mode1_latency: got %0d, want 2", v1_rise_cyc - last_cyc); end
    checks++; if (c0_l !== 24'h000002) begin errors++; $display("FAIL offset_left: got %h, want 000002", c0_l); end
    checks++; if (c0_r !== 24'hFFFFFC) begin errors++; $display("FAIL offset_right: got %h, want fffffc", c0_r); end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] el, er;
    restart(1'b0);
    for (int i = 1; i <= 5; i++) begin
      el = DATA_W'(i * 32'h111111);
      er = el ^ 24'hFFFFFF;
      send_frame(el, er, 1, 2 * SLOT_W);
      if (i == 4) begin
        checks++; if (overflow0 !== 1'b0) begin errors++; $display("FAIL ovf_after4: got %b, want 0", overflow0); end
      end
    end
    checks++; if (overflow0 !== 1'b1) begin errors++; $display("FAIL ovf_after5: got %b, want 1", overflow0); end
    for (int i = 1; i <= 4; i++) begin
      el = DATA_W'(i * 32'h111111);
      er = el ^ 24'hFFFFFF;
      checks++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL pop%0d_valid: got %b, want 1", i, out_valid0); end
      checks++; if (out_left0 !== el) begin errors++; $display("FAIL pop%0d_left: got %h, want %h", i, out_left0, el); end
      checks++; if (out_right0 !== er) begin errors++; $display("FAIL pop%0d_right: got %h, want %h", i, out_right0, er); end
      out_ready = 1'b1;
      @(posedge sys_clk); #1;
      out_ready = 1'b0;
    end
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL drained_valid: got %b, want 0", out_valid0); end
    ovf_clr = 1'b1;
    @(posedge sys_clk); #1;
    ovf_clr = 1'b0;
    checks++; if (overflow0 !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b, want 0", overflow0); end
  endtask

  task automatic test_abort();
    restart(1'b1);
    send_frame(24'hC3C3C3, 24'h3C3C3C, 1, SLOT_W + 10);
    @(posedge sys_clk); #1;
    enable = 1'b0;
    repeat (3) begin
      @(posedge sys_clk); #1;
    end
    checks++; if (bclk0 !== 1'b0) begin errors++; $display("FAIL abort_bclk: got %b, want 0", bclk0); end
    checks++; if (ws0 !== 1'b0) begin errors++; $display("FAIL abort_ws: got %b, want 0", ws0); end
    repeat (600) @(posedge sys_clk);
    #1;
    checks++; if (v0_hi != 0) begin errors++; $display("FAIL abort_push: got %0d valid cycles, want 0", v0_hi); end
    restart(1'b1);
    send_frame(24'h13579B, 24'h2468AC, 1, 2 * SLOT_W);
    checks++; if (c0_l !== 24'h13579B) begin errors++; $display("FAIL resume_left: got %h, want 13579b", c0_l); end
    checks++; if (c0_r !== 24'h2468AC) begin errors++; $display("FAIL resume_right: got %h, want 2468ac", c0_r); end
    checks++; if (v0_hi != 1) begin errors++; $display("FAIL resume_pulse: got %0d valid cycles, want 1", v0_hi); end
  endtask

  initial begin
    test_reset();
    test_clocking();
    test_mode0();
    test_mode1();
    test_backpressure();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_rx_master.md
# i2s_rx_master

Parametrised I2S master receiver: generates BCLK and WS from `sys_clk`, deserialises stereo `sdata` into left/right sample words, and buffers complete frames in a small FIFO with a valid/ready output. It sits between the external ADC/codec pins and the audio filter chain. It supports configurable sample width, slot width, BCLK rate, Philips-I2S or left-justified framing, and backpressure with overflow reporting.

## Interface
- `DATA_W`, 24: sample width in bits, 8..32.
- `SLOT_W`, 32: BCLK periods per channel slot. Requirement: `SLOT_W >= DATA_W + 1`.
- `BCLK_DIV`, 4: `sys_clk` cycles per BCLK half-period, >= 2.
- `MODE`, 0: framing selection.
  - 0 = Philips I2S: MSB one BCLK after the WS edge.
  - 1 = left-justified: MSB on the WS edge.
- `FIFO_DEPTH`, 4: frame FIFO depth, power of 2, >= 2.

Ports (one clock `sys_clk`; reset `rstn` is synchronous and active-low):
- `sys_clk`  in  1  system clock; all logic on rising edge.
- `rstn`  in  1  synchronous active-low reset.
- `enable`  in  1  run control; low = clocks idle.
- `sdata`  in  1  serial data from the codec.
- `bclk`  out  1  bit clock, registered.
- `ws`  out  1  word select, registered; 0 = left, 1 = right.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  consumer accepts a frame.
- `out_left`  out  DATA_W  left sample of the head frame, two's complement.
- `out_right`  out  DATA_W  right sample of the head frame.
- `overflow`  out  1  sticky; a frame was dropped.
- `ovf_clr`  in  1  clears `overflow`.

## Operation
- Divider `div_cnt` counts 0..BCLK_DIV-1. At terminal count, `bclk` toggles and `div_cnt` returns to 0.
- Rise edge: the `sys_clk` edge at which `bclk` goes 0→1. `sdata` is sampled on this edge.
- Fall edge: the edge at which `bclk` goes 1→0.
  - `bit_cnt` (0..2·SLOT_W-1, wraps) advances on each fall edge.
  - `ws` updates on the same fall edge: `ws = (bit_cnt >= SLOT_W)` for the new `bit_cnt`.
- Slot bit index `k = bit_cnt mod SLOT_W`. Offset `d = 1` when MODE=0, `d = 0` when MODE=1.
- Captured bits: indices `k = d .. d+DATA_W-1`, shifted in MSB-first. All other bits are ignored.
- Capture sequence:
  - When bit `k = d+DATA_W-1` of the left slot is sampled, the shift register is latched into `left_hold`.
  - When the same bit of the right slot is sampled, the frame `{left_hold, shift}` is pushed on the next `sys_clk` edge.
- FIFO behaviour:
  - Pop occurs when `out_valid && out_ready`.
  - Push while full without a pop: the frame is dropped, the FIFO is unchanged, and `overflow` is set.
  - Push and pop in the same cycle while full: both are performed and there is no overflow.
  - Push and pop in the same cycle while empty: the push is stored and `out_valid` rises on the next cycle (no bypass).
- `overflow` priority: set has priority over `ovf_clr` in the same cycle.
- `enable` low:
  - `bclk` and `ws` are forced to 0; `div_cnt`, `bit_cnt` and the shift register are cleared.
  - Any partial frame is discarded.
  - FIFO contents and the output side keep working.
- `enable` rising: counting starts from `div_cnt = 0`, `bit_cnt = 0`. The first rise edge is BCLK_DIV cycles later.
- Reset values:
  - `bclk` = 0, `ws` = 0, `out_valid` = 0, `overflow` = 0.
  - FIFO empty; `out_left` / `out_right` read as 0.
  - All counters and holds are 0.
- Reset mid-frame: everything returns to the reset state on the next edge and the partial frame is lost.

## Timing
- BCLK period = 2·BCLK_DIV `sys_clk` cycles. WS period = 2·SLOT_W BCLK periods.
- `ws` changes only on fall edges. `sdata` is expected to change on fall edges and is sampled on the following rise edge.
- Latency: `out_valid` rises exactly 2 `sys_clk` edges after the rise edge that samples the last right data bit.
  - Edge 1: frame written to the FIFO.
  - Edge 2: count visible.
- `out_left` / `out_right` are valid whenever `out_valid = 1`, and hold stable until popped.
- Throughput: at most one frame per WS period. Pop rate is one frame per cycle.

## Test plan
- Reset: hold `rstn = 0` for 5 cycles with `enable = 1` → `bclk`, `ws`, `out_valid` and `overflow` are all 0. After release, the first `bclk` rise occurs at cycle BCLK_DIV.
- Clocking, defaults (DATA_W=24, SLOT_W=32, BCLK_DIV=4):
  - `bclk` period is 8 cycles and `ws` period is 512 cycles.
  - `ws` toggles only coincident with `bclk` falling.
- MODE=0, left=0xA5A5A5, right=0x5A5A5A driven MSB at k=1, `out_ready = 1` → `out_left` = 0xA5A5A5, `out_right` = 0x5A5A5A. `out_valid` pulses 1 cycle, 2 cycles after the last sample edge.
- MODE=1, left=0x800001, right=0x7FFFFE driven MSB at k=0 → exact values recovered. A MODE=0 bench fed the same stream yields left=0x000002 shifted pattern (verifies offset).
- Backpressure, FIFO_DEPTH=4, `out_ready = 0`, 5 frames sent:
  - 4 frames stored, `overflow` = 1 after frame 5, and frame 5 is lost.
  - Popping 4 frames yields frames 1–4 in order.
  - `ovf_clr` then returns `overflow` to 0.
- Drop `enable` at bit 10 of the right slot, then re-enable: no frame is pushed for the aborted frame. The next full frame is captured correctly, starting from `ws = 0`.
